// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with stalling
// memory handshakes, sticky illegal/timeout faults and a retired-instruction counter.
module multicycle_control #(
    parameter int OPCODE_W = 11,
    parameter int ALUOP_W  = 4,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 32,
    parameter bit EN_MOVZ  = 1'b1
) (
    input  logic                CLK_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                zero_i,
    input  logic                imem_ready_i,
    input  logic                dmem_ready_i,
    output logic                imem_req_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_src_o,
    output logic                reg2loc_o,
    output logic                alusrc_o,
    output logic                mem2reg_o,
    output logic                regwrite_o,
    output logic                memread_o,
    output logic                memwrite_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [1:0]          signop_o,
    output logic [2:0]          state_o,
    output logic                illegal_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    retired_o
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd7
    } state_e;
    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_B, C_CBZ, C_LDUR, C_STUR, C_MOVZ} cls_e;

    localparam logic [ALUOP_W-1:0] A_AND   = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] A_ORR   = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] A_ADD   = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] A_SUB   = ALUOP_W'(4'b0110);
    localparam logic [ALUOP_W-1:0] A_PASSB = ALUOP_W'(4'b0111);
    localparam logic [15:0]        WAIT_LAST = 16'(TIMEOUT - 1);

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d, dec_cls;
    logic [ALUOP_W-1:0]   aluop_q, aluop_d, dec_aluop;
    logic [1:0]           signop_q, signop_d, dec_signop;
    logic                 reg2loc_q, reg2loc_d, alusrc_q, alusrc_d, mem2reg_q, mem2reg_d;
    logic [15:0]          wait_q, wait_d;
    logic                 illegal_q, illegal_d, timeout_q, timeout_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 wait_inc, expired, keep_ctrl;

    always_comb begin
        dec_cls   = C_NONE;
        dec_aluop = '0;
        casez (opcode_i)
            11'b?0001010???: begin dec_cls = C_R;    dec_aluop = A_AND;   end
            11'b?0101010???: begin dec_cls = C_R;    dec_aluop = A_ORR;   end
            11'b?0?01011???: begin dec_cls = C_R;    dec_aluop = A_ADD;   end
            11'b?1?01011???: begin dec_cls = C_R;    dec_aluop = A_SUB;   end
            11'b?0?10001???: begin dec_cls = C_I;    dec_aluop = A_ADD;   end
            11'b?1?10001???: begin dec_cls = C_I;    dec_aluop = A_SUB;   end
            11'b?00101?????: begin dec_cls = C_B;                         end
            11'b?011010????: begin dec_cls = C_CBZ;  dec_aluop = A_PASSB; end
            11'b11111000010: begin dec_cls = C_LDUR; dec_aluop = A_ADD;   end
            11'b??111000000: begin dec_cls = C_STUR; dec_aluop = A_ADD;   end
            11'b110100101??: if (EN_MOVZ) begin dec_cls = C_MOVZ; dec_aluop = A_PASSB; end
            default: ;
        endcase
        dec_signop = (dec_cls inside {C_LDUR, C_STUR}) ? 2'b01 :
                     (dec_cls == C_B) ? 2'b10 : (dec_cls == C_CBZ) ? 2'b11 : 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        imem_req_o = 1'b0;
        ir_write_o = 1'b0;
        pc_write_o = 1'b0;
        pc_src_o   = 1'b0;
        regwrite_o = 1'b0;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        wait_inc   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_write_o = imem_ready_i;
                wait_inc   = !imem_ready_i;
                state_d    = imem_ready_i ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = (dec_cls == C_NONE) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                pc_write_o = cls_q inside {C_B, C_CBZ};
                pc_src_o   = (cls_q == C_B) || (cls_q == C_CBZ && zero_i);
                state_d    = pc_write_o ? S_FETCH : (cls_q inside {C_LDUR, C_STUR}) ? S_MEM : S_WB;
            end
            S_MEM: begin
                memread_o  = cls_q == C_LDUR;
                memwrite_o = cls_q == C_STUR;
                pc_write_o = memwrite_o && dmem_ready_i;
                wait_inc   = !dmem_ready_i;
                state_d    = !dmem_ready_i ? S_MEM : memwrite_o ? S_FETCH : S_WB;
            end
            S_WB: begin
                regwrite_o = 1'b1;
                pc_write_o = 1'b1;
                state_d    = S_FETCH;
            end
            default: ;
        endcase
        expired = wait_inc && wait_q == WAIT_LAST;
        if (expired) state_d = S_FAULT;
        // Strobes are forced low while reset is held so an aborted instruction leaves no side effects.
        if (reset_i) begin
            imem_req_o = 1'b0;
            ir_write_o = 1'b0;
            pc_write_o = 1'b0;
            pc_src_o   = 1'b0;
            regwrite_o = 1'b0;
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
        end
        keep_ctrl = state_d inside {S_EXEC, S_MEM, S_WB};
        aluop_d   = (state_q == S_DECODE) ? dec_aluop : keep_ctrl ? aluop_q : '0;
        signop_d  = (state_q == S_DECODE) ? dec_signop : keep_ctrl ? signop_q : '0;
        alusrc_d  = (state_q == S_DECODE) ? dec_cls inside {C_I, C_LDUR, C_STUR, C_MOVZ} : keep_ctrl && alusrc_q;
        reg2loc_d = (state_q == S_DECODE) ? dec_cls inside {C_STUR, C_CBZ} : keep_ctrl && reg2loc_q;
        mem2reg_d = (state_q == S_DECODE) ? dec_cls == C_LDUR : keep_ctrl && mem2reg_q;
        wait_d    = (state_d != state_q) ? '0 : wait_inc ? wait_q + 16'd1 : wait_q;
        illegal_d = illegal_q || (state_q == S_DECODE && dec_cls == C_NONE);
        timeout_d = timeout_q || expired;
        retired_d = retired_q + CNT_W'(pc_write_o);
    end

    always_ff @(posedge CLK_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            aluop_q   <= '0;
            signop_q  <= '0;
            alusrc_q  <= 1'b0;
            reg2loc_q <= 1'b0;
            mem2reg_q <= 1'b0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            aluop_q   <= aluop_d;
            signop_q  <= signop_d;
            alusrc_q  <= alusrc_d;
            reg2loc_q <= reg2loc_d;
            mem2reg_q <= mem2reg_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    assign state_o   = state_q;
    assign aluop_o   = aluop_q;
    assign signop_o  = signop_q;
    assign alusrc_o  = alusrc_q;
    assign reg2loc_o = reg2loc_q;
    assign mem2reg_o = mem2reg_q;
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign retired_o = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table of single instructions with hand-computed state traces and controls,
// plus directed sequences for faults, timeout, counter wrap and reset mid-instruction.
module tb_multicycle_control;
    logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [10:0] opcode = '0;
    logic        a_imem_req, a_ir_write, a_pc_write, a_pc_src, a_reg2loc, a_alusrc, a_mem2reg;
    logic        a_regwrite, a_memread, a_memwrite, a_illegal, a_timeout;
    logic [3:0]  a_aluop, a_retired;
    logic [1:0]  a_signop;
    logic [2:0]  a_state;
    logic        b_imem_req, b_ir_write, b_pc_write, b_pc_src, b_reg2loc, b_alusrc, b_mem2reg;
    logic        b_regwrite, b_memread, b_memwrite, b_illegal, b_timeout;
    logic [3:0]  b_aluop;
    logic [31:0] b_retired;
    logic [1:0]  b_signop;
    logic [2:0]  b_state;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(4), .CNT_W(4), .EN_MOVZ(1'b1)) u_a (
        .CLK_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(a_imem_req), .ir_write_o(a_ir_write), .pc_write_o(a_pc_write), .pc_src_o(a_pc_src),
        .reg2loc_o(a_reg2loc), .alusrc_o(a_alusrc), .mem2reg_o(a_mem2reg), .regwrite_o(a_regwrite),
        .memread_o(a_memread), .memwrite_o(a_memwrite), .aluop_o(a_aluop), .signop_o(a_signop),
        .state_o(a_state), .illegal_o(a_illegal), .timeout_o(a_timeout), .retired_o(a_retired)
    );

    multicycle_control #(.EN_MOVZ(1'b0)) u_b (
        .CLK_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(b_imem_req), .ir_write_o(b_ir_write), .pc_write_o(b_pc_write), .pc_src_o(b_pc_src),
        .reg2loc_o(b_reg2loc), .alusrc_o(b_alusrc), .mem2reg_o(b_mem2reg), .regwrite_o(b_regwrite),
        .memread_o(b_memread), .memwrite_o(b_memwrite), .aluop_o(b_aluop), .signop_o(b_signop),
        .state_o(b_state), .illegal_o(b_illegal), .timeout_o(b_timeout), .retired_o(b_retired)
    );

    typedef struct {
        logic [10:0] op;
        logic        z;
        int          dly;
        int          cyc;
        logic [31:0] seq;
        logic [3:0]  alu;
        logic [1:0]  sg;
        logic        src, r2l, m2r;
        int          nreg, nmrd, nmwr;
        logic        pcs;
    } vec_t;

    typedef struct {
        int          cyc, nreg, nmrd, nmwr, npc, nir, stray;
        logic [31:0] seq;
        logic [3:0]  alu;
        logic [1:0]  sg;
        logic        src, r2l, m2r, pcs;
    } res_t;

    int total = 0, bad = 0;
    vec_t vt[14];
    res_t r;
    logic [3:0] cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] all_a();
        return 32'({a_imem_req, a_ir_write, a_pc_write, a_pc_src, a_reg2loc, a_alusrc, a_mem2reg,
                    a_regwrite, a_memread, a_memwrite, a_aluop, a_signop, a_state, a_illegal,
                    a_timeout, a_retired});
    endfunction

    // Drives one instruction from FETCH until its pc_write; dmem answers dly cycles into MEM.
    task automatic run_instr(input logic [10:0] op, input logic z, input int dly, output res_t o);
        o = '{default: 0};
        while (o.npc == 0 && o.cyc < 30) begin
            opcode = op;
            zero = z;
            imem_ready = 1'b1;
            dmem_ready = o.cyc >= 3 + dly;
            #1;
            o.seq = (o.seq << 4) | 32'(a_state);
            if (a_state == 3'd2) begin
                o.alu = a_aluop;
                o.sg  = a_signop;
                o.src = a_alusrc;
                o.r2l = a_reg2loc;
            end
            if (a_state == 3'd4) o.m2r = a_mem2reg;
            o.nir   += int'(a_ir_write);
            o.nreg  += int'(a_regwrite);
            o.nmrd  += int'(a_memread);
            o.nmwr  += int'(a_memwrite);
            o.stray += int'(a_regwrite && a_state != 3'd4) + int'(a_memwrite && a_state != 3'd3);
            if (a_pc_write) begin
                o.npc++;
                o.pcs = a_pc_src;
            end
            o.cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        vt[0]  = '{11'b10001011000, 1'b0, 0, 4, 32'h124,     4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[1]  = '{11'b11001011000, 1'b0, 0, 4, 32'h124,     4'b0110, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[2]  = '{11'b10001010000, 1'b0, 0, 4, 32'h124,     4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[3]  = '{11'b10101010000, 1'b0, 0, 4, 32'h124,     4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[4]  = '{11'b10010001000, 1'b0, 0, 4, 32'h124,     4'b0010, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[5]  = '{11'b11010001000, 1'b0, 0, 4, 32'h124,     4'b0110, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[6]  = '{11'b11010010100, 1'b0, 0, 4, 32'h124,     4'b0111, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0};
        vt[7]  = '{11'b11111000010, 1'b0, 0, 5, 32'h1234,    4'b0010, 2'b01, 1'b1, 1'b0, 1'b1, 1, 1, 0, 1'b0};
        vt[8]  = '{11'b11111000010, 1'b0, 3, 8, 32'h1233334, 4'b0010, 2'b01, 1'b1, 1'b0, 1'b1, 1, 4, 0, 1'b0};
        vt[9]  = '{11'b11111000000, 1'b0, 0, 4, 32'h123,     4'b0010, 2'b01, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0};
        vt[10] = '{11'b11111000000, 1'b0, 2, 6, 32'h12333,   4'b0010, 2'b01, 1'b1, 1'b1, 1'b0, 0, 0, 3, 1'b0};
        vt[11] = '{11'b00010100000, 1'b0, 0, 3, 32'h12,      4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1};
        vt[12] = '{11'b10110100000, 1'b1, 0, 3, 32'h12,      4'b0111, 2'b11, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1};
        vt[13] = '{11'b10110100000, 1'b0, 0, 3, 32'h12,      4'b0111, 2'b11, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", all_a(), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        cnt = 4'd0;
        for (int i = 0; i < 14; i++) begin
            run_instr(vt[i].op, vt[i].z, vt[i].dly, r);
            cnt = cnt + 4'd1;
            chk($sformatf("v%0d_cycles", i),  32'(r.cyc),  32'(vt[i].cyc));
            chk($sformatf("v%0d_states", i),  r.seq,       vt[i].seq);
            chk($sformatf("v%0d_aluop", i),   32'(r.alu),  32'(vt[i].alu));
            chk($sformatf("v%0d_signop", i),  32'(r.sg),   32'(vt[i].sg));
            chk($sformatf("v%0d_alusrc", i),  32'(r.src),  32'(vt[i].src));
            chk($sformatf("v%0d_reg2loc", i), 32'(r.r2l),  32'(vt[i].r2l));
            chk($sformatf("v%0d_mem2reg", i), 32'(r.m2r),  32'(vt[i].m2r));
            chk($sformatf("v%0d_regwr", i),   32'(r.nreg), 32'(vt[i].nreg));
            chk($sformatf("v%0d_memrd", i),   32'(r.nmrd), 32'(vt[i].nmrd));
            chk($sformatf("v%0d_memwr", i),   32'(r.nmwr), 32'(vt[i].nmwr));
            chk($sformatf("v%0d_pcsrc", i),   32'(r.pcs),  32'(vt[i].pcs));
            chk($sformatf("v%0d_pcwrite", i), 32'(r.npc),  32'd1);
            chk($sformatf("v%0d_irwrite", i), 32'(r.nir),  32'd1);
            chk($sformatf("v%0d_stray", i),   32'(r.stray), 32'd0);
            chk($sformatf("v%0d_retired", i), 32'(a_retired), 32'(cnt));
        end
        chk("nomovz_state", 32'(b_state), 32'd7);
        chk("nomovz_illegal", 32'(b_illegal), 32'd1);
        chk("nomovz_retired", b_retired, 32'd6);

        do_reset();
        opcode = 11'b00000000000;
        imem_ready = 1'b1;
        tick();
        tick();
        chk("illegal_state", 32'(a_state), 32'd7);
        chk("illegal_flag", 32'(a_illegal), 32'd1);
        opcode = 11'b10001011000;
        repeat (4) tick();
        chk("illegal_held_state", 32'(a_state), 32'd7);
        chk("illegal_sticky", 32'(a_illegal), 32'd1);
        chk("fault_no_req", 32'(a_imem_req), 32'd0);
        chk("fault_retired", 32'(a_retired), 32'd0);
        chk("fault_no_timeout", 32'(a_timeout), 32'd0);

        do_reset();
        imem_ready = 1'b0;
        repeat (3) tick();
        chk("wait3_state", 32'(a_state), 32'd0);
        chk("wait3_req", 32'(a_imem_req), 32'd1);
        chk("wait3_timeout", 32'(a_timeout), 32'd0);
        tick();
        chk("wait4_state", 32'(a_state), 32'd7);
        chk("wait4_timeout", 32'(a_timeout), 32'd1);
        reset = 1'b1;
        tick();
        chk("timeout_reset_outputs", all_a(), 32'h0);

        do_reset();
        for (int i = 0; i < 17; i++) run_instr(11'b10001011000, 1'b0, 0, r);
        chk("retired_wrap", 32'(a_retired), 32'd1);

        do_reset();
        opcode = 11'b11111000000;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (3) tick();
        chk("stur_in_mem", 32'(a_state), 32'd3);
        chk("stur_memwrite", 32'(a_memwrite), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_state", 32'(a_state), 32'd0);
        chk("abort_memwrite", 32'(a_memwrite), 32'd0);
        chk("abort_pcwrite", 32'(a_pc_write), 32'd0);
        chk("abort_retired", 32'(a_retired), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle LEGv8 control unit for the next-generation datapath, replacing the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memories that may stall. It drives registered datapath controls using the team's existing opcode map, aluop and signop encodings. It also flags illegal opcodes, memory timeouts and counts retired instructions.

Parameters:
OPCODE_W, 11, opcode field width (instr[31:21]); fixed to 11 for LEGv8 decode
ALUOP_W, 4, ALU operation select width
TIMEOUT, 16, max wait cycles on imem_ready/dmem_ready before fault (1..65535)
CNT_W, 32, width of retired-instruction counter
EN_MOVZ, 1, 1 = MOVZ decoded; 0 = MOVZ treated as illegal

Ports:
CLK  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instr[31:21] from instruction register
zero  in  1  ALU zero flag, sampled in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_write  out  1  one-cycle IR load strobe
pc_write  out  1  one-cycle PC update strobe
pc_src  out  1  0 = PC+4, 1 = branch target (valid with pc_write)
reg2loc, alusrc, mem2reg  out  1 each  datapath muxes
regwrite, memread, memwrite  out  1 each  register/memory enables
aluop  out  ALUOP_W  AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111
signop  out  2  00 I-type, 01 D-type, 10 B, 11 CB
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, FAULT 7
illegal  out  1  sticky: undecodable opcode
timeout  out  1  sticky: memory wait exceeded TIMEOUT
retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Reset: state=FETCH; every output 0 (no X on any output, ever); retired=0; wait counter=0. Reset mid-instruction aborts it with no pc_write/regwrite/memwrite.
- Decode patterns (casez, ?=don't care): AND ?0001010???, ORR ?0101010???, ADD ?0?01011???, SUB ?1?01011???, ADDI ?0?10001???, SUBI ?1?10001???, B ?00101?????, CBZ ?011010????, LDUR 11111000010, STUR ??111000000, MOVZ 110100101??. First match in this order wins.
- FETCH: imem_req=1 until imem_ready. Cycle imem_ready=1: ir_write=1, go DECODE. Wait counter increments on each not-ready cycle; reaching TIMEOUT -> FAULT, timeout=1.
- DECODE (1 cycle): latch opcode, register aluop/signop/reg2loc/alusrc/mem2reg per class (R-type: alusrc0 reg2loc0; imm: alusrc1 signop00; LDUR/STUR: alusrc1 aluop ADD signop01, STUR reg2loc1; CBZ: reg2loc1 aluop PASSB signop11; B: signop10; MOVZ: alusrc1 aluop PASSB). Unused fields drive 0. No match -> FAULT, illegal=1.
- EXEC (1 cycle): B: pc_write=1, pc_src=1, go FETCH. CBZ: pc_write=1, pc_src=zero, go FETCH. LDUR/STUR -> MEM. Others -> WB.
- MEM: LDUR memread=1, STUR memwrite=1, held until dmem_ready (same timeout rule). On dmem_ready: STUR pc_write=1 pc_src=0 -> FETCH; LDUR -> WB.
- WB (1 cycle): regwrite=1, mem2reg=1 for LDUR else 0, pc_write=1, pc_src=0, go FETCH.
- retired increments on every cycle pc_write=1. Exactly one pc_write per instruction; regwrite only in WB; memwrite only in MEM.
- Latency with zero-wait memories: R/I/MOVZ 4 cycles, LDUR 5, STUR 4, B/CBZ 3.
- FAULT: all strobes 0, held until reset; illegal/timeout sticky. Wait counter clears on every state change.

Test Plan:
- Reset then ADD (opcode 10001011000), memories always ready -> states 0,1,2,4,0; regwrite=1 only in WB; aluop=0010; retired=1 after 4 cycles.
- LDUR 11111000010 with dmem_ready delayed 3 cycles -> memread held 4 cycles, mem2reg=1 in WB, total 8 cycles, one pc_write.
- CBZ 10110100000 with zero=1 then zero=0 -> pc_write in EXEC with pc_src=1 then 0; regwrite/memwrite never asserted.
- Opcode 00000000000 -> FAULT after DECODE, illegal=1 sticky; EN_MOVZ=0 with MOVZ opcode -> illegal=1.
- imem_ready held 0, TIMEOUT=4 -> FAULT after 4 wait cycles, timeout=1; reset clears to FETCH with all outputs 0.
- CNT_W=4, run 17 ADDs -> retired wraps to 1; reset asserted during MEM of STUR -> no memwrite next cycle, state=FETCH.
